// File: rtl/lcd_word_viewer.sv
// lcd_word_viewer: on a key press, reads one data-memory word and shows it
// as 8 upper-case hex characters on line 1 of an HD44780-compatible LCD.
module lcd_word_viewer #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int unsigned           NUM_WORDS      = 16,
  parameter int unsigned           POWERUP_CYCLES = 750000,
  parameter int unsigned           EN_CYCLES      = 12,
  parameter int unsigned           WAIT_CYCLES    = 2500,
  parameter int unsigned           CLEAR_WAIT     = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_in,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  data_mem_rd_en_out,
  output logic [7:0]            lcd_data_out,
  output logic                  lcd_on_out,
  output logic                  lcd_blon_out,
  output logic                  lcd_rw_out,
  output logic                  lcd_en_out,
  output logic                  lcd_rs_out,
  output logic                  busy_out
);

  typedef enum logic [2:0] {
    S_PWR_WAIT, S_INIT, S_IDLE, S_MEM_REQ, S_MEM_CAP, S_HOME, S_CHARS, S_ADV
  } state_e;

  typedef enum logic [1:0] {PH_SETUP, PH_EN_HI, PH_EN_LO} phase_e;

  localparam logic [31:0] PWR_LAST   = 32'(POWERUP_CYCLES - 1);
  localparam logic [31:0] EN_LAST    = 32'(EN_CYCLES - 1);
  localparam logic [31:0] WAIT_LAST  = 32'(WAIT_CYCLES - 1);
  localparam logic [31:0] CLEAR_LAST = 32'(CLEAR_WAIT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    BASE_ADDR + ADDR_WIDTH'(4 * (NUM_WORDS - 1));

  state_e                state_q, state_d;
  phase_e                phase_q, phase_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_en_q, rd_en_d;
  logic [7:0]            data_q, data_d;
  logic                  en_q, en_d;
  logic                  rs_q, rs_d;
  logic                  busy_q, busy_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  key_prev_q, key_prev_d;
  logic                  trigger;
  logic                  wr_done;
  logic [31:0]           lo_last;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h38;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  function automatic logic [7:0] hex_char(input logic [DATA_WIDTH-1:0] w,
                                          input logic [2:0] i);
    logic [3:0] n;
    n = w[{3'd7 - i, 2'b00} +: 4];
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign trigger = key_prev_q & ~sync2_q;
  assign lo_last = (!rs_q && data_q == 8'h01) ? CLEAR_LAST : WAIT_LAST;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    rd_en_d    = rd_en_q;
    data_d     = data_q;
    en_d       = en_q;
    rs_d       = rs_q;
    busy_d     = busy_q;
    sync1_d    = read_in;
    sync2_d    = sync1_q;
    key_prev_d = sync2_q;
    wr_done    = 1'b0;

    case (state_q)
      S_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d = S_INIT;
          phase_d = PH_SETUP;
          cnt_d   = '0;
          idx_d   = '0;
          rs_d    = 1'b0;
          data_d  = init_cmd(3'd0);
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_IDLE: begin
        if (trigger) begin
          state_d = S_MEM_REQ;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_MEM_REQ: begin
        state_d = S_MEM_CAP;
        rd_en_d = 1'b0;
      end
      S_MEM_CAP: begin
        word_d  = mem_data_in;
        state_d = S_HOME;
        phase_d = PH_SETUP;
        cnt_d   = '0;
        rs_d    = 1'b0;
        data_d  = 8'h80;
      end
      S_ADV: begin
        addr_d  = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + ADDR_WIDTH'(4);
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        // INIT, HOME and CHARS share the byte-write sequencer; wr_done then
        // selects the next byte or the next state.
        case (phase_q)
          PH_SETUP: begin
            phase_d = PH_EN_HI;
            en_d    = 1'b1;
            cnt_d   = '0;
          end
          PH_EN_HI: begin
            if (cnt_q == EN_LAST) begin
              phase_d = PH_EN_LO;
              en_d    = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          default: begin
            if (cnt_q == lo_last) begin
              cnt_d   = '0;
              phase_d = PH_SETUP;
              wr_done = 1'b1;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        endcase

        if (wr_done) begin
          case (state_q)
            S_INIT: begin
              if (idx_q == 3'd3) begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end else begin
                idx_d  = idx_q + 3'd1;
                data_d = init_cmd(idx_q + 3'd1);
              end
            end
            S_HOME: begin
              state_d = S_CHARS;
              idx_d   = '0;
              rs_d    = 1'b1;
              data_d  = hex_char(word_q, 3'd0);
            end
            default: begin
              if (idx_q == 3'd7) begin
                state_d = S_ADV;
              end else begin
                idx_d  = idx_q + 3'd1;
                data_d = hex_char(word_q, idx_q + 3'd1);
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PWR_WAIT;
      phase_q    <= PH_SETUP;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      addr_q     <= BASE_ADDR;
      rd_en_q    <= 1'b0;
      data_q     <= '0;
      en_q       <= 1'b0;
      rs_q       <= 1'b0;
      busy_q     <= 1'b1;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      key_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      data_q     <= data_d;
      en_q       <= en_d;
      rs_q       <= rs_d;
      busy_q     <= busy_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      key_prev_q <= key_prev_d;
    end
  end

  assign addr_out           = addr_q;
  assign data_mem_rd_en_out = rd_en_q;
  assign lcd_data_out       = data_q;
  assign lcd_en_out         = en_q;
  assign lcd_rs_out         = rs_q;
  assign busy_out           = busy_q;
  assign lcd_rw_out         = 1'b0;
  assign lcd_on_out         = 1'b1;
  assign lcd_blon_out       = 1'b1;

endmodule

// File: doc/lcd_word_viewer.md
Name: lcd_word_viewer

Overview:
- Debug/observation block downstream of the data-memory stage.
- On each press of a board key, reads one word from data memory and shows it on line 1 of a 16x2 HD44780-compatible character LCD as 8 upper-case hex ASCII characters.
- The read address auto-advances through a configurable window.
- Shares the data-memory read port with the core: it drives the address and read-enable, and consumes the memory data output.

Parameters:
- ADDR_WIDTH, 32, width of addr_out.
- DATA_WIDTH, 32, width of mem_data_in; must be 32 (8 hex chars).
- BASE_ADDR, 0, first address displayed after reset.
- NUM_WORDS, 16, number of words in the viewing window.
- POWERUP_CYCLES, 750000, idle cycles after reset before the first LCD command.
- EN_CYCLES, 12, cycles lcd_en_out is held high per LCD write.
- WAIT_CYCLES, 2500, cycles after EN falls before the next write.
- CLEAR_WAIT, 100000, post-EN wait used instead of WAIT_CYCLES after the clear command (0x01).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- read_in  in  1  display trigger; active-low push key, asynchronous to clk.
- mem_data_in  in  DATA_WIDTH  data memory read data.
- addr_out  out  ADDR_WIDTH  data memory byte address.
- data_mem_rd_en_out  out  1  data memory read enable.
- lcd_data_out  out  8  LCD data bus.
- lcd_on_out  out  1  LCD power.
- lcd_blon_out  out  1  backlight.
- lcd_rw_out  out  1  0 = write.
- lcd_en_out  out  1  LCD enable strobe.
- lcd_rs_out  out  1  0 = command, 1 = data.
- busy_out  out  1  high while initialising or displaying.

Behaviour:

Clocking and reset:
- One clock; all state updates on the rising edge of clk.
- rst is synchronous and active-high.
- Reset values:
  - addr_out = BASE_ADDR
  - data_mem_rd_en_out = 0
  - lcd_data_out = 0x00
  - lcd_en_out = 0, lcd_rs_out = 0, lcd_rw_out = 0
  - lcd_on_out = 1, lcd_blon_out = 1
  - busy_out = 1
  - FSM in PWR_WAIT, all counters 0
- lcd_rw_out, lcd_on_out and lcd_blon_out are constant after reset.
- Reset asserted mid-operation aborts immediately. lcd_en_out is 0 at the edge following rst sampled high, and the full init sequence is re-run.

Trigger:
- read_in passes through a 2-FF synchroniser.
- A trigger is a falling edge of the synchronised signal: previous 1, current 0.
- A trigger is honoured only in IDLE. Triggers while busy_out = 1 are dropped, not queued.

LCD write sub-sequence (one byte):
- SETUP, 1 cycle: drive rs/data, en = 0.
- EN_HI, EN_CYCLES cycles: en = 1.
- EN_LO: en = 0 for WAIT_CYCLES cycles, or CLEAR_WAIT cycles if the byte was command 0x01.
- rs and data stay stable from SETUP through the end of EN_LO.

Main FSM:
- PWR_WAIT: count POWERUP_CYCLES, then go to INIT.
- INIT: write commands 0x38, 0x0C, 0x01, 0x06 in that order, then go to IDLE with busy_out = 0.
- IDLE: busy_out = 0. On trigger, go to MEM_REQ and set busy_out = 1.
- MEM_REQ, 1 cycle: data_mem_rd_en_out = 1 with addr_out stable.
- MEM_CAP, 1 cycle: rd_en = 0; mem_data_in is registered into the word buffer at the end of this cycle. Read latency is fixed at 1.
- HOME: write command 0x80 (cursor to line 1, column 0).
- CHARS: write 8 data bytes (rs = 1), nibble [31:28] first and [3:0] last.
  - Nibble 0–9 maps to 0x30 + n.
  - Nibble A–F maps to 0x37 + n (0x41–0x46).
- ADV, 1 cycle:
  - If addr_out = BASE_ADDR + 4*(NUM_WORDS−1), set addr_out = BASE_ADDR (wrap).
  - Otherwise addr_out += 4.
  - Then go to IDLE.

Other rules:
- addr_out changes only in reset and in ADV.
- data_mem_rd_en_out is high only in MEM_REQ.
- The display is not cleared between words; the 8 characters overwrite columns 0–7.

Test Plan:
All scenarios use POWERUP_CYCLES=20, EN_CYCLES=2, WAIT_CYCLES=4, CLEAR_WAIT=10, NUM_WORDS=4, BASE_ADDR=0. With these values one normal write takes 7 cycles.

1. Reset then idle:
   - Stimulus: rst high for 2 cycles, then release.
   - Required: outputs at reset values; first lcd_en_out rise 21 cycles after release.
   - Required: 4 EN pulses with data 0x38, 0x0C, 0x01, 0x06 and rs = 0.
   - Required: busy_out falls after the 0x06 wait completes.
2. Single display:
   - Stimulus: memory word at address 0 = 0xDEADBEEF; pulse read_in low for 5 cycles.
   - Required: one rd_en cycle with addr_out = 0.
   - Required: command 0x80, then data bytes 0x44,0x45,0x41,0x44,0x42,0x45,0x45,0x46 with rs = 1.
   - Required: addr_out = 4 and busy_out = 0 afterwards.
3. Hex mapping boundaries:
   - Stimulus: word 0x09A0F5C1.
   - Required: bytes 0x30,0x39,0x41,0x30,0x46,0x35,0x43,0x31.
4. Address wrap:
   - Stimulus: 5 consecutive triggers.
   - Required: rd_en addresses 0, 4, 8, 12, 0; addr_out = 4 at the end.
5. Trigger while busy:
   - Stimulus: a second falling edge on read_in during CHARS.
   - Required: no extra memory read; exactly 9 LCD writes for the first trigger; addr_out advances by 4 only.
6. Reset mid-display:
   - Stimulus: assert rst during an EN_HI of CHARS.
   - Required: lcd_en_out = 0 on the next edge; addr_out = 0; the init sequence of scenario 1 repeats.
